// File: rtl/alu_bk_pkg.sv
// Shared types and constants for the Brent-Kung slice-chained ALU.
// Slice width and sequencer states used by the sequencer and result stages.
package alu_bk_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_bk_flag_calc.sv
// Result flag derivation for an add/sub result.
// b_msb is the effective (possibly inverted) B operand MSB.
module alu_bk_flag_calc #(
  parameter int W = 16
) (
  input  logic         a_msb,
  input  logic         b_msb,
  input  logic [W-1:0] res,
  input  logic         carry,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  always_comb begin
    cout = carry;
    ovf  = (a_msb == b_msb) && (res[W-1] != a_msb);
    zero = (res == '0);
  end

endmodule

// File: rtl/alu_bk_chain_seq.sv
// Wide add/sub sequencer driving an external 4-bit adder slice,
// one slice per cycle, with valid/ready on both sides.
module alu_bk_chain_seq
  import alu_bk_pkg::*;
#(
  parameter int NSLICE = 4,
  localparam int W = SLICE_W * NSLICE,
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_sub,
  output logic [SLICE_W-1:0] slice_a,
  output logic [SLICE_W-1:0] slice_b,
  output logic               slice_cin,
  input  logic [SLICE_W-1:0] slice_sum,
  input  logic               slice_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic               out_zero
);

  seq_state_e state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic            last;
  logic            f_cout, f_ovf, f_zero;
  logic [W-1:0]    res_ins;

  assign last = (idx_q == IDXW'(NSLICE - 1));

  // Slice mux and result insertion at the current index
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    res_ins   = res_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        res_ins[i*SLICE_W +: SLICE_W] = slice_sum;
        if (state_q == RUN) begin
          slice_a = a_q[i*SLICE_W +: SLICE_W];
          slice_b = b_q[i*SLICE_W +: SLICE_W];
        end
      end
    end
    if (state_q == RUN) slice_cin = carry_q;
  end

  alu_bk_flag_calc #(.W(W)) u_flags (
    .a_msb (a_q[W-1]),
    .b_msb (b_q[W-1]),
    .res   (res_ins),
    .carry (slice_c),
    .cout  (f_cout),
    .ovf   (f_ovf),
    .zero  (f_zero)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_sum   = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_ins;
        carry_d = slice_c;
        if (last) begin
          cout_d  = f_cout;
          ovf_d   = f_ovf;
          zero_d  = f_zero;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_bk_chain_seq.sv
// Directed bench for alu_bk_chain_seq with a behavioural 4-bit adder slice.
// Expected results are hand-computed per vector.
module tb_alu_bk_chain_seq;

  localparam int NSLICE = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_sum;
  logic         slice_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb {slice_c, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  alu_bk_chain_seq #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_cin (slice_cin),
    .slice_sum (slice_sum),
    .slice_c   (slice_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf, input logic e_zero,
                        input int hold);
    int lat;
    logic [W-1:0] held;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sub = 1'b0;
    check({tag, "_run_cin"}, 32'(slice_cin), 32'(sub));
    check({tag, "_run_a0"}, 32'(slice_a), 32'(a[3:0]));
    check({tag, "_run_rdy"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    // out_valid is first seen #1 after edge T+lat-1 when counted this way
    check({tag, "_latency"}, 32'(lat), 32'(NSLICE + 1) - 32'd1 + 32'd1);
    check({tag, "_sum"}, 32'(out_sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(out_cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(e_ovf));
    check({tag, "_zero"}, 32'(out_zero), 32'(e_zero));
    held = out_sum;
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        in_a = 16'hAAAA;
        in_b = 16'h5555;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_sum"}, 32'(out_sum), 32'(held));
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_slice"}, 32'({slice_a, slice_b, slice_cin}), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sub = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);
    check("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    run_op("add_ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0, 0);
    run_op("sub_eq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1, 0, 1, 0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 1, 0, 0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0);
    run_op("sub_brw", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 0, 0, 0, 0);
    run_op("hold", 16'h1000, 16'h0234, 1'b0, 16'h1234, 0, 0, 0, 10);
    run_op("after_hold", 16'h0010, 16'h0020, 1'b0, 16'h0030, 0, 0, 0, 0);

    // Abort mid-RUN at idx=2
    in_a = 16'h4321;
    in_b = 16'h1111;
    in_sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_slice_a_idx2", 32'(slice_a), 32'h3);
    rst = 1'b1;
    tick();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    check("abort_rdy_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_rdy_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op("fresh", 16'h1234, 16'h1111, 1'b0, 16'h2345, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
